// File: rtl/cordic_mult_pkg.sv
// Shared types and defaults for the approximate CORDIC multiplier.
package cordic_mult_pkg;

  localparam int W_IN_DEF  = 8;
  localparam int W_OUT_DEF = 16;
  localparam int ITER      = W_IN_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CORR,
    DONE
  } state_t;

endpackage

// File: rtl/approx_lor_adder.sv
// Lower-part-OR approximate adder: the low APPROX_BITS bits are ORed, the upper
// part is an exact add whose carry-in is the AND of the top approximate bits.
// The addend is optionally negated (exact two's complement) before the add.
module approx_lor_adder #(
  parameter int W           = 16,
  parameter int APPROX_BITS = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] b_eff;

  assign b_eff = sub_i ? -b_i : b_i;

  if (APPROX_BITS == 0) begin : g_exact
    assign sum_o = a_i + b_eff;
  end else begin : g_apx
    logic                    cin;
    logic [W-APPROX_BITS-1:0] hi;

    assign cin   = a_i[APPROX_BITS-1] & b_eff[APPROX_BITS-1];
    assign hi    = a_i[W-1:APPROX_BITS] + b_eff[W-1:APPROX_BITS]
                 + {{(W-APPROX_BITS-1){1'b0}}, cin};
    assign sum_o = {hi, a_i[APPROX_BITS-1:0] | b_eff[APPROX_BITS-1:0]};
  end

endmodule

// File: rtl/cordic_multiplier_approx_2tn.sv
// Sequential signed multiplier on a linear-mode CORDIC datapath. One iteration
// per cycle from the top bit down, then a single residual correction step.
//
// state | meaning
// IDLE  | waiting for start, operands captured on start
// RUN   | one CORDIC iteration per cycle, i = W_IN-1 .. 0
// CORR  | fold residual r in {-1,0,+1} into acc, publish y
// DONE  | done held high until start drops
module cordic_multiplier_approx_2tn
  import cordic_mult_pkg::*;
#(
  parameter int W_IN        = W_IN_DEF,
  parameter int W_OUT       = W_OUT_DEF,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W_IN-1:0]  x,
  input  logic [W_IN-1:0]  z,
  output logic [W_OUT-1:0] y,
  output logic             done
);

  localparam int IW = $clog2(W_IN);
  localparam int RW = W_IN + 2;

  state_t           state_q;
  logic [W_OUT-1:0] xr_q;
  logic [W_OUT-1:0] acc_q;
  logic [W_OUT-1:0] y_q;
  logic [RW-1:0]    r_q;
  logic [IW-1:0]    i_q;
  logic             done_q;

  logic [W_OUT-1:0] add_b;
  logic             add_sub;
  logic [W_OUT-1:0] acc_d;
  logic [RW-1:0]    step;
  logic [RW-1:0]    r_d;

  // Addend select: shifted multiplicand while iterating, plain xr for the
  // correction. A negative residual means subtract in both cases.
  always_comb begin
    add_b   = xr_q << i_q;
    add_sub = r_q[RW-1];
    step    = {{(RW-1){1'b0}}, 1'b1} << i_q;
    r_d     = r_q[RW-1] ? (r_q + step) : (r_q - step);
    if (state_q == CORR) begin
      add_b = xr_q;
    end
  end

  approx_lor_adder #(
    .W           (W_OUT),
    .APPROX_BITS (APPROX_BITS)
  ) u_acc_add (
    .a_i   (acc_q),
    .b_i   (add_b),
    .sub_i (add_sub),
    .sum_o (acc_d)
  );

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      xr_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            xr_q    <= {{(W_OUT-W_IN){x[W_IN-1]}}, x};
            r_q     <= {{2{z[W_IN-1]}}, z};
            acc_q   <= '0;
            i_q     <= IW'(W_IN - 1);
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          r_q   <= r_d;
          if (i_q == '0) begin
            state_q <= CORR;
          end else begin
            i_q <= i_q - IW'(1);
          end
        end
        CORR: begin
          if (r_q != '0) begin
            acc_q <= acc_d;
            y_q   <= acc_d;
          end else begin
            y_q   <= acc_q;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y    = y_q;
  assign done = done_q;

endmodule

// File: tb/tb_cordic_multiplier_approx_2tn.sv
// Bench for cordic_multiplier_approx_2tn: an approximate (2 LSB) and an exact
// instance run side by side on the same stimulus; expected products are queued
// at start and popped when done rises.
module tb_cordic_multiplier_approx_2tn;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  x;
  logic [7:0]  z;
  logic [15:0] y_a;
  logic [15:0] y_e;
  logic        done_a;
  logic        done_e;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_a_q[$];
  logic [15:0] exp_e_q[$];

  always #5 clk = ~clk;

  cordic_multiplier_approx_2tn #(.W_IN(8), .W_OUT(16), .APPROX_BITS(2)) u_apx (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .z(z), .y(y_a), .done(done_a)
  );

  cordic_multiplier_approx_2tn #(.W_IN(8), .W_OUT(16), .APPROX_BITS(0)) u_ex (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .z(z), .y(y_e), .done(done_e)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference approx_add: OR in the low ab bits, AND-carry into the exact upper add.
  function automatic logic [15:0] aadd(input logic [15:0] a, input logic [15:0] b, input int ab);
    logic [15:0] mask, lo, hi;
    logic        c;
    if (ab == 0) return a + b;
    mask = 16'((1 << ab) - 1);
    lo   = (a | b) & mask;
    c    = a[ab-1] & b[ab-1];
    hi   = ((a >> ab) + (b >> ab) + 16'(c)) << ab;
    return hi | lo;
  endfunction

  // Reference CORDIC multiply using the approximate add above.
  function automatic logic [15:0] model(input logic [7:0] xv, input logic [7:0] zv, input int ab);
    logic [15:0] xr, acc, t;
    int          r;
    xr  = {{8{xv[7]}}, xv};
    r   = int'($signed(zv));
    acc = '0;
    for (int i = 7; i >= 0; i--) begin
      t = xr << i;
      if (r >= 0) begin
        acc = aadd(acc, t, ab);
        r   = r - (1 << i);
      end else begin
        acc = aadd(acc, -t, ab);
        r   = r + (1 << i);
      end
    end
    if (r == 1) acc = aadd(acc, xr, ab);
    else if (r == -1) acc = aadd(acc, -xr, ab);
    return acc;
  endfunction

  task automatic run_op(input int xv, input int zv);
    logic [15:0] ea, ee;
    int          lat, err;
    @(negedge clk);
    x     = 8'(xv);
    z     = 8'(zv);
    start = 1'b1;
    exp_a_q.push_back(model(8'(xv), 8'(zv), 2));
    exp_e_q.push_back(16'(xv * zv));
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    x     = 8'($urandom);
    z     = 8'($urandom);
    while (!done_a && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val("latency", lat, 10);
    check_val("done_sync", int'(done_e), 1);
    ea = exp_a_q.size() > 0 ? exp_a_q.pop_front() : 16'h0;
    ee = exp_e_q.size() > 0 ? exp_e_q.pop_front() : 16'h0;
    check_val("y_apx", int'($signed(y_a)), int'($signed(ea)));
    check_val("y_exact", int'($signed(y_e)), int'($signed(ee)));
    err = int'($signed(y_a)) - xv * zv;
    if (err < 0) err = -err;
    check_val("err_bound", int'(err <= 9), 1);
    if (xv % 4 == 0) check_val("x4_exact", int'($signed(y_a)), xv * zv);
    @(posedge clk);
    @(negedge clk);
    check_val("done_drop", int'(done_a), 0);
    check_val("y_hold", int'($signed(y_e)), int'($signed(ee)));
  endtask

  int corners[12] = '{-128, -127, -86, -2, -1, 0, 1, 2, 3, 85, 126, 127};

  initial begin
    int rises, seen;
    logic prev;
    logic [15:0] ea, ee;

    rst_n = 1'b1;
    start = 1'b1;
    x     = 8'd3;
    z     = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_done", int'(done_a | done_e), 0);
    check_val("rst_y", int'(y_a | y_e), 0);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("idle_done", int'(done_a | done_e), 0);

    run_op(4, -7);
    check_val("c_4x-7", int'($signed(y_e)), -28);
    check_val("c_4x-7_apx", int'($signed(y_a)), -28);
    run_op(-128, -128);
    check_val("c_max", int'($signed(y_e)), 16384);
    check_val("c_max_apx", int'($signed(y_a)), 16384);
    run_op(0, 99);
    check_val("c_zero", int'($signed(y_a)), 0);
    run_op(-128, 127);
    check_val("c_min", int'($signed(y_e)), -16256);

    // Held start: one completion, done stays high, no retrigger.
    @(negedge clk);
    x     = 8'(5);
    z     = 8'(-11);
    start = 1'b1;
    exp_a_q.push_back(model(8'(5), 8'(-11), 2));
    exp_e_q.push_back(16'(-55));
    rises = 0;
    prev  = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a && !prev) rises++;
      prev = done_a;
    end
    check_val("hs_rises", rises, 1);
    check_val("hs_held", int'(done_a & done_e), 1);
    ea = exp_a_q.pop_front();
    ee = exp_e_q.pop_front();
    check_val("hs_y_apx", int'($signed(y_a)), int'($signed(ea)));
    check_val("hs_y_exact", int'($signed(y_e)), -55);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("hs_drop", int'(done_a | done_e), 0);
    check_val("hs_y_keep", int'($signed(y_e)), int'($signed(ee)));

    // Abort in RUN, then restart.
    @(negedge clk);
    x     = 8'd7;
    z     = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check_val("abort_done", int'(done_a | done_e), 0);
    check_val("abort_y", int'(y_a | y_e), 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a || done_e) seen = 1;
    end
    check_val("abort_no_stale", seen, 0);
    exp_a_q.delete();
    exp_e_q.delete();
    run_op(8, 3);
    check_val("restart_y", int'($signed(y_a)), 24);

    foreach (corners[i]) begin
      foreach (corners[j]) begin
        run_op(corners[i], corners[j]);
      end
    end
    repeat (300) begin
      run_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
